// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - next-PC select and PC write control for the fetch stage
// Optional macro: NPC_PERF_EN enables the redirect/stall performance counters.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] EXC_VEC  = 32'h00400004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        flush,
  output logic        pend,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  pend_cls_q, pend_cls_d;

  logic        req_any;
  logic [1:0]  req_cls;
  logic [31:0] req_tgt;
  logic [31:0] pc_seq;
  logic [31:0] pc_raw;

  // Pick the highest-priority redirect request; lower ones are simply discarded
  always_comb begin
    req_any = exc_req | eret | jmp | br_taken;
    req_cls = 2'd0;
    req_tgt = br_target;
    if (exc_req) begin
      req_cls = 2'd3;
      req_tgt = EXC_VEC;
    end else if (eret) begin
      req_cls = 2'd2;
      req_tgt = epc;
    end else if (jmp) begin
      req_cls = 2'd1;
      req_tgt = jmp_target;
    end
  end

  assign pc_seq  = pc_in + 32'd4;
  assign pc_next = pc_raw & 32'hFFFF_FFFC;

  // Next-state and output decode; a redirect seen under stall is parked until the stall clears
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pend_cls_d = pend_cls_q;
    pc_raw     = pc_seq;
    pc_we      = 1'b0;
    flush      = 1'b0;
    pend       = 1'b0;
    if (rst) begin
      state_d    = ST_BOOT;
      pend_tgt_d = 32'd0;
      pend_cls_d = 2'd0;
      pc_raw     = RESET_PC;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_raw  = RESET_PC;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            pc_we = 1'b1;
            if (req_any) begin
              pc_raw = req_tgt;
              flush  = 1'b1;
            end
          end else if (req_any) begin
            pend_tgt_d = req_tgt;
            pend_cls_d = req_cls;
            state_d    = ST_PEND;
          end
        end
        ST_PEND: begin
          pend   = 1'b1;
          pc_raw = pend_tgt_q;
          if (stall) begin
            if (req_any && (req_cls > pend_cls_q)) begin
              pend_tgt_d = req_tgt;
              pend_cls_d = req_cls;
            end
          end else begin
            pc_we   = 1'b1;
            flush   = 1'b1;
            state_d = ST_RUN;
            if (req_any && (req_cls > pend_cls_q)) begin
              pc_raw = req_tgt;
            end
          end
        end
        default: begin
          pc_raw  = RESET_PC;
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State registers; reset is folded into the _d logic
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pend_tgt_q <= pend_tgt_d;
    pend_cls_q <= pend_cls_d;
  end

`ifdef NPC_PERF_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count applied redirects and stalled cycles outside BOOT
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (rst) begin
      redirect_cnt_d = 32'd0;
      stall_cnt_d    = 32'd0;
    end else begin
      if (flush) begin
        redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
      if (stall && ((state_q == ST_RUN) || (state_q == ST_PEND))) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    redirect_cnt_q <= redirect_cnt_d;
    stall_cnt_q    <= stall_cnt_d;
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule
